// File: rtl/fib_rec_bist_ctrl.sv
// BIST sequencer for the fib_rec recognizer: drives codes 0..N_VECTORS-1, waits a settle time,
// samples f and checks it against a built-in golden table, reporting errors and a response mask.
module fib_rec_bist_ctrl #(
   parameter int unsigned N_VECTORS     = 16,
   parameter int unsigned SETTLE_CYCLES = 1,
   parameter int unsigned ERR_W         = 5
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_start,
   input  logic             i_abort,
   output logic [3:0]       o_bcd_out,
   input  logic             i_f_in,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_pass,
   output logic [ERR_W-1:0] o_err_count,
   output logic             o_fail_valid,
   output logic [3:0]       o_first_fail_code,
   output logic [15:0]      o_hit_mask
);

   localparam int unsigned CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam int unsigned SETTLE_LOAD_INT = (SETTLE_CYCLES > 0) ? (SETTLE_CYCLES - 1) : 0;
   localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_LOAD_INT);
   localparam logic [3:0] LAST_IDX = 4'(N_VECTORS - 1);
   // f=1 for codes 0,1,2,3,5,8; non-BCD codes are never Fibonacci
   localparam logic [15:0] GOLDEN = 16'h012F;

   typedef enum logic [2:0] {
      StIdle,
      StDrive,
      StWait,
      StSample,
      StDone
   } state_t;

   state_t           r_state;
   logic [3:0]       r_idx;
   logic [CNT_W-1:0] r_settle;
   logic [3:0]       r_bcd_out;
   logic             r_busy;
   logic             r_done;
   logic             r_pass;
   logic [ERR_W-1:0] r_err_count;
   logic             r_fail_valid;
   logic [3:0]       r_first_fail_code;
   logic [15:0]      r_hit_mask;

   logic             w_golden;
   logic             w_mismatch;
   logic             w_err_sat;
   logic [ERR_W-1:0] w_err_next;

   always_comb begin
      w_golden   = GOLDEN[r_idx];
      w_mismatch = (i_f_in != w_golden);
      w_err_sat  = &r_err_count;
      w_err_next = r_err_count;
      if (w_mismatch && !w_err_sat) begin
         w_err_next = r_err_count + ERR_W'(1);
      end
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_state           <= StIdle;
         r_idx             <= '0;
         r_settle          <= '0;
         r_bcd_out         <= '0;
         r_busy            <= 1'b0;
         r_done            <= 1'b0;
         r_pass            <= 1'b0;
         r_err_count       <= '0;
         r_fail_valid      <= 1'b0;
         r_first_fail_code <= '0;
         r_hit_mask        <= '0;
      end else if (i_abort && (r_state != StIdle)) begin
         // results are left intact so a host can inspect a partial run
         r_state   <= StIdle;
         r_bcd_out <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_pass    <= 1'b0;
      end else begin
         unique case (r_state)
            StIdle, StDone: begin
               if (i_start && !i_abort) begin
                  r_state           <= StDrive;
                  r_idx             <= '0;
                  r_busy            <= 1'b1;
                  r_done            <= 1'b0;
                  r_pass            <= 1'b0;
                  r_err_count       <= '0;
                  r_fail_valid      <= 1'b0;
                  r_first_fail_code <= '0;
                  r_hit_mask        <= '0;
               end
            end
            StDrive: begin
               r_bcd_out <= r_idx;
               r_settle  <= SETTLE_LOAD;
               r_state   <= (SETTLE_CYCLES > 0) ? StWait : StSample;
            end
            StWait: begin
               if (r_settle == '0) begin
                  r_state <= StSample;
               end else begin
                  r_settle <= r_settle - CNT_W'(1);
               end
            end
            StSample: begin
               r_hit_mask[r_idx] <= i_f_in;
               r_err_count       <= w_err_next;
               if (w_mismatch && !r_fail_valid) begin
                  r_fail_valid      <= 1'b1;
                  r_first_fail_code <= r_idx;
               end
               if (r_idx == LAST_IDX) begin
                  r_state <= StDone;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_pass  <= (w_err_next == '0);
               end else begin
                  r_idx   <= r_idx + 4'd1;
                  r_state <= StDrive;
               end
            end
            default: begin
               r_state <= StIdle;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   assign o_bcd_out         = r_bcd_out;
   assign o_busy            = r_busy;
   assign o_done            = r_done;
   assign o_pass            = r_pass;
   assign o_err_count       = r_err_count;
   assign o_fail_valid      = r_fail_valid;
   assign o_first_fail_code = r_first_fail_code;
   assign o_hit_mask        = r_hit_mask;

endmodule

// File: tb/tb_fib_rec_bist_ctrl.sv
// Directed bench for fib_rec_bist_ctrl: behavioural fib_rec models with injected faults on f_in,
// plus a second instance built with SETTLE_CYCLES=0.
module tb_fib_rec_bist_ctrl;

   logic        clk;
   logic        reset;
   logic        start, abort;
   logic [3:0]  bcd;
   logic        f;
   logic        busy, done, pass, fv;
   logic [4:0]  err;
   logic [3:0]  ffc;
   logic [15:0] hit;

   logic        start_z, abort_z;
   logic [3:0]  bcd_z;
   logic        f_z;
   logic        busy_z, done_z, pass_z, fv_z;
   logic [4:0]  err_z;
   logic [3:0]  ffc_z;
   logic [15:0] hit_z;

   int mode;
   int n_cmp;
   int n_bad;

   // 0: golden, 1: stuck at 0, 2: stuck at 1, 3: code 9 wrongly flagged
   function automatic logic model_f(input logic [3:0] c, input int m);
      logic g;
      case (c)
         4'd0, 4'd1, 4'd2, 4'd3, 4'd5, 4'd8: g = 1'b1;
         default: g = 1'b0;
      endcase
      case (m)
         1: return 1'b0;
         2: return 1'b1;
         3: return g | (c == 4'd9);
         default: return g;
      endcase
   endfunction

   assign f   = model_f(bcd, mode);
   assign f_z = model_f(bcd_z, 0);

   fib_rec_bist_ctrl #(.N_VECTORS(16), .SETTLE_CYCLES(1), .ERR_W(5)) dut (
      .i_clk(clk), .i_reset(reset), .i_start(start), .i_abort(abort), .o_bcd_out(bcd),
      .i_f_in(f), .o_busy(busy), .o_done(done), .o_pass(pass), .o_err_count(err),
      .o_fail_valid(fv), .o_first_fail_code(ffc), .o_hit_mask(hit)
   );

   fib_rec_bist_ctrl #(.N_VECTORS(16), .SETTLE_CYCLES(0), .ERR_W(5)) dut_z (
      .i_clk(clk), .i_reset(reset), .i_start(start_z), .i_abort(abort_z), .o_bcd_out(bcd_z),
      .i_f_in(f_z), .o_busy(busy_z), .o_done(done_z), .o_pass(pass_z), .o_err_count(err_z),
      .o_fail_valid(fv_z), .o_first_fail_code(ffc_z), .o_hit_mask(hit_z)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic run_edges(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // the edge consumed here is edge 0 of the run
   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      run_edges(2);
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
      n_cmp++; if (pass !== 1'b0) begin n_bad++; $display("FAIL reset_pass: got %b want 0", pass); end
      n_cmp++; if (bcd !== 4'd0) begin n_bad++; $display("FAIL reset_bcd: got %h want 0", bcd); end
      n_cmp++; if (err !== 5'd0) begin n_bad++; $display("FAIL reset_err: got %0d want 0", err); end
      n_cmp++; if (hit !== 16'h0000) begin n_bad++; $display("FAIL reset_hit: got %h want 0000", hit); end
      n_cmp++; if ({fv, ffc} !== 5'd0) begin n_bad++; $display("FAIL reset_fail: got %b/%h want 0/0", fv, ffc); end
      #2;
      reset = 1'b1;
      run_edges(1);
   endtask

   task automatic test_golden();
      mode = 0;
      pulse_start();
      n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL golden_busy_rise: got %b want 1", busy); end
      run_edges(47);
      n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL golden_done_early: got %b want 0 at edge 47", done); end
      run_edges(1);
      n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL golden_done: got %b want 1 at edge 48", done); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL golden_busy_fall: got %b want 0", busy); end
      n_cmp++; if (pass !== 1'b1) begin n_bad++; $display("FAIL golden_pass: got %b want 1", pass); end
      n_cmp++; if (err !== 5'd0) begin n_bad++; $display("FAIL golden_err: got %0d want 0", err); end
      n_cmp++; if (fv !== 1'b0) begin n_bad++; $display("FAIL golden_fv: got %b want 0", fv); end
      n_cmp++; if (hit !== 16'h012F) begin n_bad++; $display("FAIL golden_hit: got %h want 012f", hit); end
      n_cmp++; if (bcd !== 4'd15) begin n_bad++; $display("FAIL golden_bcd_hold: got %h want f", bcd); end
      run_edges(3);
      n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL golden_done_level: got %b want 1", done); end
   endtask

   task automatic test_stuck0();
      mode = 1;
      pulse_start();
      n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL s0_done_clear: got %b want 0", done); end
      run_edges(48);
      n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL s0_done: got %b want 1", done); end
      n_cmp++; if (err !== 5'd6) begin n_bad++; $display("FAIL s0_err: got %0d want 6", err); end
      n_cmp++; if (fv !== 1'b1) begin n_bad++; $display("FAIL s0_fv: got %b want 1", fv); end
      n_cmp++; if (ffc !== 4'd0) begin n_bad++; $display("FAIL s0_ffc: got %0d want 0", ffc); end
      n_cmp++; if (hit !== 16'h0000) begin n_bad++; $display("FAIL s0_hit: got %h want 0000", hit); end
      n_cmp++; if (pass !== 1'b0) begin n_bad++; $display("FAIL s0_pass: got %b want 0", pass); end
   endtask

   task automatic test_stuck1();
      mode = 2;
      pulse_start();
      run_edges(48);
      n_cmp++; if (err !== 5'd10) begin n_bad++; $display("FAIL s1_err: got %0d want 10", err); end
      n_cmp++; if (ffc !== 4'd4) begin n_bad++; $display("FAIL s1_ffc: got %0d want 4", ffc); end
      n_cmp++; if (hit !== 16'hFFFF) begin n_bad++; $display("FAIL s1_hit: got %h want ffff", hit); end
      n_cmp++; if (pass !== 1'b0) begin n_bad++; $display("FAIL s1_pass: got %b want 0", pass); end
   endtask

   task automatic test_faulty9_restart();
      mode = 3;
      pulse_start();
      run_edges(48);
      n_cmp++; if (err !== 5'd1) begin n_bad++; $display("FAIL f9_err: got %0d want 1", err); end
      n_cmp++; if (ffc !== 4'd9) begin n_bad++; $display("FAIL f9_ffc: got %0d want 9", ffc); end
      n_cmp++; if (hit !== 16'h032F) begin n_bad++; $display("FAIL f9_hit: got %h want 032f", hit); end
      n_cmp++; if (fv !== 1'b1) begin n_bad++; $display("FAIL f9_fv: got %b want 1", fv); end
      mode = 0;
      pulse_start();
      n_cmp++; if (err !== 5'd0) begin n_bad++; $display("FAIL restart_err_clr: got %0d want 0", err); end
      n_cmp++; if (hit !== 16'h0000) begin n_bad++; $display("FAIL restart_hit_clr: got %h want 0000", hit); end
      n_cmp++; if ({fv, ffc} !== 5'd0) begin n_bad++; $display("FAIL restart_fail_clr: got %b/%h want 0/0", fv, ffc); end
      n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL restart_busy: got %b want 1", busy); end
      run_edges(48);
      n_cmp++; if (pass !== 1'b1) begin n_bad++; $display("FAIL restart_pass: got %b want 1", pass); end
      n_cmp++; if (hit !== 16'h012F) begin n_bad++; $display("FAIL restart_hit: got %h want 012f", hit); end
   endtask

   task automatic test_abort();
      mode = 0;
      pulse_start();
      run_edges(9);
      start = 1'b1;
      run_edges(1);
      start = 1'b0;
      // edge 10 of the original run leaves code 3 driven; a restart would still show code 2
      n_cmp++; if (bcd !== 4'd3) begin n_bad++; $display("FAIL busy_start_bcd: got %0d want 3", bcd); end
      n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL busy_start_busy: got %b want 1", busy); end
      run_edges(9);
      abort = 1'b1;
      run_edges(1);
      abort = 1'b0;
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy: got %b want 0", busy); end
      n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL abort_done: got %b want 0", done); end
      n_cmp++; if (bcd !== 4'd0) begin n_bad++; $display("FAIL abort_bcd: got %0d want 0", bcd); end
      n_cmp++; if (hit !== 16'h002F) begin n_bad++; $display("FAIL abort_hit_hold: got %h want 002f", hit); end
      run_edges(5);
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_stays_idle: got %b want 0", busy); end
      pulse_start();
      run_edges(47);
      n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL post_abort_early: got %b want 0", done); end
      run_edges(1);
      n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL post_abort_done: got %b want 1", done); end
      n_cmp++; if (pass !== 1'b1) begin n_bad++; $display("FAIL post_abort_pass: got %b want 1", pass); end
   endtask

   task automatic test_reset_mid();
      mode = 1;
      pulse_start();
      run_edges(8);
      n_cmp++; if (err !== 5'd2) begin n_bad++; $display("FAIL mid_err_partial: got %0d want 2", err); end
      #2;
      reset = 1'b0;
      #1;
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mid_reset_busy: got %b want 0", busy); end
      n_cmp++; if (err !== 5'd0) begin n_bad++; $display("FAIL mid_reset_err: got %0d want 0", err); end
      n_cmp++; if ({fv, ffc} !== 5'd0) begin n_bad++; $display("FAIL mid_reset_fail: got %b/%h want 0/0", fv, ffc); end
      n_cmp++; if (bcd !== 4'd0) begin n_bad++; $display("FAIL mid_reset_bcd: got %0d want 0", bcd); end
      n_cmp++; if (hit !== 16'h0000) begin n_bad++; $display("FAIL mid_reset_hit: got %h want 0000", hit); end
      #1;
      reset = 1'b1;
      run_edges(3);
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mid_reset_idle: got %b want 0", busy); end
   endtask

   task automatic test_settle0();
      start_z = 1'b1;
      @(posedge clk);
      #1;
      start_z = 1'b0;
      n_cmp++; if (busy_z !== 1'b1) begin n_bad++; $display("FAIL z_busy: got %b want 1", busy_z); end
      run_edges(31);
      n_cmp++; if (done_z !== 1'b0) begin n_bad++; $display("FAIL z_done_early: got %b want 0 at edge 31", done_z); end
      run_edges(1);
      n_cmp++; if (done_z !== 1'b1) begin n_bad++; $display("FAIL z_done: got %b want 1 at edge 32", done_z); end
      n_cmp++; if (pass_z !== 1'b1) begin n_bad++; $display("FAIL z_pass: got %b want 1", pass_z); end
      n_cmp++; if (hit_z !== 16'h012F) begin n_bad++; $display("FAIL z_hit: got %h want 012f", hit_z); end
      n_cmp++; if (err_z !== 5'd0) begin n_bad++; $display("FAIL z_err: got %0d want 0", err_z); end
   endtask

   initial begin
      n_cmp   = 0;
      n_bad   = 0;
      mode    = 0;
      start   = 1'b0;
      abort   = 1'b0;
      start_z = 1'b0;
      abort_z = 1'b0;
      reset   = 1'b0;
      test_reset();
      test_golden();
      test_stuck0();
      test_stuck1();
      test_faulty9_restart();
      test_abort();
      test_reset_mid();
      test_settle0();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
